video_line_capture: RTL and testbench

- Sits directly downstream of the composite sync separator and consumes its sample-rate strobes plus the raw 12-bit ADC stream.
- Averages each pair of active samples into one 8-bit luma pixel and writes the pixel into one of two ping-pong line banks.
- Announces each completed line to the scaler/framebuffer writer, which reads the bank back through a synchronous read port and releases it with an acknowledge.

---
 rtl/video_line_capture_if.sv | 40 ++++
 rtl/video_line_capture.sv | 176 +++++++++++++++++
 tb/tb_video_line_capture.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_line_capture_if.sv
// Sample-strobe capture, readback and line-handshake signals of video_line_capture.
// VIDEO_CAPTURE_TESTPAT_EN adds the test_pattern select.
interface video_line_capture_if;
  logic        sample_valid;
  logic [11:0] adc_data;
  logic        h_sync_pulse;
  logic        v_sync_pulse;
  logic        active_video;
  logic        rd_bank;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        line_ack;
  logic        line_ready;
  logic        ready_bank;
  logic [8:0]  line_num;
  logic [9:0]  line_len;
  logic        frame_start;
  logic [15:0] overrun_cnt;
`ifdef VIDEO_CAPTURE_TESTPAT_EN
  logic        test_pattern;
`endif

  modport master (
`ifdef VIDEO_CAPTURE_TESTPAT_EN
    output test_pattern,
`endif
    output sample_valid, adc_data, h_sync_pulse, v_sync_pulse, active_video,
    output rd_bank, rd_addr, line_ack,
    input  rd_data, line_ready, ready_bank, line_num, line_len, frame_start, overrun_cnt
  );

  modport slave (
`ifdef VIDEO_CAPTURE_TESTPAT_EN
    input  test_pattern,
`endif
    input  sample_valid, adc_data, h_sync_pulse, v_sync_pulse, active_video,
    input  rd_bank, rd_addr, line_ack,
    output rd_data, line_ready, ready_bank, line_num, line_len, frame_start, overrun_cnt
  );
endinterface

// File: rtl/video_line_capture.sv
// Pairs active ADC samples into 8-bit luma and fills two ping-pong line banks.
// Define VIDEO_CAPTURE_TESTPAT_EN to substitute an idx^line_num test pattern for the ADC luma.
module video_line_capture #(
  parameter int OUT_WIDTH   = 640,
  parameter int BLACK_LEVEL = 3000,
  parameter int LUMA_SHIFT  = 2,
  parameter int MAX_LINE    = 511
) (
  input logic clk,
  input logic rst,
  video_line_capture_if.slave vid
);

  localparam logic [9:0]  LP_OUT_W    = 10'(OUT_WIDTH);
  localparam logic [11:0] LP_BLACK    = 12'(BLACK_LEVEL);
  localparam logic [8:0]  LP_MAX_LINE = 9'(MAX_LINE);

  typedef enum logic [2:0] {
    S_WAIT_FRAME,
    S_WAIT_LINE,
    S_SKIP,
    S_CAPTURE,
    S_COMMIT
  } state_t;

  function automatic logic [7:0] f_luma(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    logic [11:0] avg;
    logic [11:0] lvl;
    sum = {1'b0, a} + {1'b0, b};
    avg = sum[12:1];
    if (avg <= LP_BLACK) return 8'd0;
    lvl = (avg - LP_BLACK) >> LUMA_SHIFT;
    return (lvl > 12'd255) ? 8'hFF : lvl[7:0];
  endfunction

  state_t      r_state;
  logic [1:0]  r_full;
  logic        r_wr_bank;
  logic [9:0]  r_idx;
  logic        r_have_first;
  logic [11:0] r_first;
  logic [8:0]  r_line_cnt;
  logic [8:0]  r_cap_line;
  logic        r_line_ready;
  logic        r_ready_bank;
  logic [8:0]  r_line_num;
  logic [9:0]  r_line_len;
  logic        r_frame_start;
  logic [15:0] r_overrun;
  logic        r_wr_vld_p1;
  logic [10:0] r_wr_addr_p1;
  logic [7:0]  r_wr_data_p1;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [0:2047];

  logic        w_vs;
  logic        w_hs;
  logic        w_start;
  logic        w_cap_smp;
  logic        w_pair_wr;
  logic [8:0]  w_line_inc;
  logic [8:0]  w_line_cap;
  logic [7:0]  w_luma;

  assign w_vs       = vid.sample_valid & vid.v_sync_pulse;
  assign w_hs       = vid.sample_valid & vid.h_sync_pulse;
  assign w_line_inc = (r_line_cnt == LP_MAX_LINE) ? r_line_cnt : r_line_cnt + 9'd1;
  // A capture starting on an h_sync strobe records the already-incremented line number.
  assign w_line_cap = vid.h_sync_pulse ? w_line_inc : r_line_cnt;
  assign w_start    = (r_state == S_WAIT_LINE) && vid.sample_valid && !vid.v_sync_pulse &&
                      vid.active_video && !(r_full[0] && r_full[1]);
  assign w_cap_smp  = (r_state == S_CAPTURE) && vid.sample_valid && !vid.v_sync_pulse &&
                      !vid.h_sync_pulse && vid.active_video;
  assign w_pair_wr  = w_cap_smp && r_have_first && (r_idx < LP_OUT_W);

`ifdef VIDEO_CAPTURE_TESTPAT_EN
  assign w_luma = vid.test_pattern ? (r_idx[7:0] ^ r_cap_line[7:0]) : f_luma(r_first, vid.adc_data);
`else
  assign w_luma = f_luma(r_first, vid.adc_data);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_WAIT_FRAME;
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_idx         <= '0;
      r_have_first  <= 1'b0;
      r_line_cnt    <= '0;
      r_cap_line    <= '0;
      r_line_ready  <= 1'b0;
      r_ready_bank  <= 1'b0;
      r_line_num    <= '0;
      r_line_len    <= '0;
      r_frame_start <= 1'b0;
      r_overrun     <= '0;
      r_wr_vld_p1   <= 1'b0;
    end else begin
      r_line_ready  <= 1'b0;
      r_frame_start <= 1'b0;
      r_wr_vld_p1   <= w_pair_wr;
      // An ack to the bank under capture is harmless: it is still FREE and COMMIT below wins.
      if (vid.line_ack) r_full[vid.rd_bank] <= 1'b0;
      if (w_vs) begin
        r_line_cnt    <= '0;
        r_frame_start <= 1'b1;
      end else if (w_hs) begin
        r_line_cnt <= w_line_inc;
      end
      if (r_state == S_COMMIT) begin
        r_full[r_wr_bank] <= 1'b1;
        r_line_ready      <= 1'b1;
        r_ready_bank      <= r_wr_bank;
        r_line_num        <= r_cap_line;
        r_line_len        <= r_idx;
        r_state           <= S_WAIT_LINE;
      end else if (w_vs) begin
        r_state <= S_WAIT_LINE;
      end else if (vid.sample_valid) begin
        case (r_state)
          S_WAIT_LINE: begin
            if (w_start) begin
              r_wr_bank    <= r_full[0];
              r_idx        <= '0;
              r_have_first <= 1'b1;
              r_cap_line   <= w_line_cap;
              r_state      <= S_CAPTURE;
            end else if (vid.active_video) begin
              if (r_overrun != 16'hFFFF) r_overrun <= r_overrun + 16'd1;
              r_state <= S_SKIP;
            end
          end
          S_SKIP: if (!vid.active_video) r_state <= S_WAIT_LINE;
          S_CAPTURE: begin
            if (vid.h_sync_pulse || !vid.active_video) begin
              r_state <= S_COMMIT;
            end else begin
              r_have_first <= !r_have_first;
              if (w_pair_wr) r_idx <= r_idx + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p0 -> p1: hold first sample of a pair, register the luma write.
  always_ff @(posedge clk) begin
    if (w_start || (w_cap_smp && !r_have_first)) r_first <= vid.adc_data;
    if (w_pair_wr) begin
      r_wr_addr_p1 <= {r_wr_bank, r_idx};
      r_wr_data_p1 <= w_luma;
    end
  end

  // Stage p1: bank RAM write, synchronous readback.
  always_ff @(posedge clk) begin
    if (r_wr_vld_p1) r_mem[r_wr_addr_p1] <= r_wr_data_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_mem[{vid.rd_bank, vid.rd_addr}];
  end

  assign vid.rd_data     = r_rd_data;
  assign vid.line_ready  = r_line_ready;
  assign vid.ready_bank  = r_ready_bank;
  assign vid.line_num    = r_line_num;
  assign vid.line_len    = r_line_len;
  assign vid.frame_start = r_frame_start;
  assign vid.overrun_cnt = r_overrun;

endmodule

// File: tb/tb_video_line_capture.sv
// Scoreboard bench for video_line_capture: expected line records and readback bytes are queued
// by the stimulus and popped by a monitor whenever the DUT presents line_ready or read data.
module tb_video_line_capture;

  typedef struct packed {
    logic       bank;
    logic [8:0] num;
    logic [9:0] len;
  } line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_line_capture_if vif();

  video_line_capture #(
    .OUT_WIDTH(640), .BLACK_LEVEL(3000), .LUMA_SHIFT(2), .MAX_LINE(511)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vif)
  );

  line_t      exp_line_q[$];
  logic [7:0] exp_rd_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  int         fs_cnt = 0;
  int         exp_fs = 0;
  logic       rd_req   = 1'b0;
  logic       rd_req_d = 1'b0;

  logic [11:0] sat_v [12] = '{4095, 4095, 2900, 2900, 3000, 3000, 3007, 3009, 4000, 3000, 3000, 4095};
  logic [7:0]  sat_l [6]  = '{8'd255, 8'd0, 8'd0, 8'd2, 8'd125, 8'd136};

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin : monitor
    line_t e;
    line_t a;
    logic [7:0] er;
    if (vif.frame_start === 1'b1) fs_cnt++;
    if (vif.line_ready === 1'b1) begin
      a = '{bank: vif.ready_bank, num: vif.line_num, len: vif.line_len};
      n_vec++;
      if (exp_line_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_line_ready: got bank=%0d num=%0d len=%0d, required no line_ready",
                 a.bank, a.num, a.len);
      end else begin
        e = exp_line_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL line_record: got bank=%0d num=%0d len=%0d, required bank=%0d num=%0d len=%0d",
                   a.bank, a.num, a.len, e.bank, e.num, e.len);
        end
      end
    end
    if (rd_req_d) begin
      n_vec++;
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %0d, required no read", vif.rd_data);
      end else begin
        er = exp_rd_q.pop_front();
        if (vif.rd_data !== er) begin
          n_fail++;
          $display("FAIL rd_data: got %0d, required %0d", vif.rd_data, er);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic smp(input logic [11:0] d, input logic act, input logic hs, input logic vs);
    @(posedge clk); #1;
    vif.sample_valid = 1'b1;
    vif.adc_data     = d;
    vif.active_video = act;
    vif.h_sync_pulse = hs;
    vif.v_sync_pulse = vs;
    @(posedge clk); #1;
    vif.sample_valid = 1'b0;
    vif.h_sync_pulse = 1'b0;
    vif.v_sync_pulse = 1'b0;
  endtask

  task automatic line(input int n, input logic [11:0] d);
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) smp(d, 1'b1, 1'b0, 1'b0);
    smp(12'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic rd_seq(input logic b, input int a0, input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vif.rd_bank = b;
      vif.rd_addr = 10'(a0 + i);
      rd_req = 1'b1;
      exp_rd_q.push_back(e);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    idle(3);
  endtask

  task automatic ack(input logic b);
    @(posedge clk); #1;
    vif.line_ack = 1'b1;
    vif.rd_bank  = b;
    @(posedge clk); #1;
    vif.line_ack = 1'b0;
  endtask

  task automatic drained(input string nm);
    chk({nm, "_lines_pending"}, exp_line_q.size(), 0);
    chk({nm, "_reads_pending"}, exp_rd_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_line_ready"},  vif.line_ready, 0);
    chk({nm, "_ready_bank"},  vif.ready_bank, 0);
    chk({nm, "_line_num"},    vif.line_num, 0);
    chk({nm, "_line_len"},    vif.line_len, 0);
    chk({nm, "_frame_start"}, vif.frame_start, 0);
    chk({nm, "_overrun_cnt"}, vif.overrun_cnt, 0);
    chk({nm, "_rd_data"},     vif.rd_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.sample_valid = 1'b0;
    vif.adc_data     = '0;
    vif.h_sync_pulse = 1'b0;
    vif.v_sync_pulse = 1'b0;
    vif.active_video = 1'b0;
    vif.rd_bank      = 1'b0;
    vif.rd_addr      = '0;
    vif.line_ack     = 1'b0;
`ifdef VIDEO_CAPTURE_TESTPAT_EN
    vif.test_pattern = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Active video before the first frame sync must not be captured.
    line(4, 12'd3100);
    chk("preframe_overrun", vif.overrun_cnt, 0);

    // Full line of 1280 samples at 3100 -> 640 pixels of luma 25.
    smp(12'd0, 1'b0, 1'b0, 1'b1); exp_fs++;
    exp_line_q.push_back('{bank: 1'b0, num: 9'd1, len: 10'd640});
    line(1280, 12'd3100);
    drained("full_line");
    chk("full_line_frame_start", fs_cnt, exp_fs);
    rd_seq(1'b0, 0, 640, 8'd25);
    ack(1'b0);

    // Saturation and black clamp.
    exp_line_q.push_back('{bank: 1'b0, num: 9'd2, len: 10'd6});
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) smp(sat_v[i], 1'b1, 1'b0, 1'b0);
    smp(12'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 6; i++) rd_seq(1'b0, i, 1, sat_l[i]);
    drained("luma");
    ack(1'b0);

    // Overrun: third line dropped, fourth line lands in the released bank 0.
    exp_line_q.push_back('{bank: 1'b0, num: 9'd3, len: 10'd2});
    line(4, 12'd3100);
    exp_line_q.push_back('{bank: 1'b1, num: 9'd4, len: 10'd2});
    line(4, 12'd3200);
    line(4, 12'd3300);
    drained("overrun");
    chk("overrun_cnt_1", vif.overrun_cnt, 1);
    ack(1'b0);
    exp_line_q.push_back('{bank: 1'b0, num: 9'd6, len: 10'd2});
    line(4, 12'd3100);
    drained("after_overrun");
    chk("overrun_cnt_hold", vif.overrun_cnt, 1);
    rd_seq(1'b1, 0, 2, 8'd50);

    // Abort in bank 1, then a short odd line must still find bank 1 FREE with line counter 0.
    ack(1'b1);
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) smp(12'd3300, 1'b1, 1'b0, 1'b0);
    smp(12'd0, 1'b0, 1'b0, 1'b1); exp_fs++;
    idle(4);
    drained("abort");
    chk("abort_frame_start", fs_cnt, exp_fs);
    exp_line_q.push_back('{bank: 1'b1, num: 9'd1, len: 10'd100});
    line(201, 12'd3300);
    drained("odd_line");
    chk("odd_line_overrun", vif.overrun_cnt, 1);
    rd_seq(1'b1, 99, 1, 8'd75);
    rd_seq(1'b1, 0, 1, 8'd75);
    ack(1'b0);
    ack(1'b1);

    // Overlong line clamps at 640 pixels.
    exp_line_q.push_back('{bank: 1'b0, num: 9'd2, len: 10'd640});
    line(1400, 12'd3400);
    drained("long_line");
    rd_seq(1'b0, 639, 1, 8'd100);
    rd_seq(1'b0, 0, 1, 8'd100);
    ack(1'b0);

`ifdef VIDEO_CAPTURE_TESTPAT_EN
    smp(12'd0, 1'b0, 1'b0, 1'b1); exp_fs++;
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    vif.test_pattern = 1'b1;
    exp_line_q.push_back('{bank: 1'b0, num: 9'd3, len: 10'd6});
    line(12, 12'd3100);
    vif.test_pattern = 1'b0;
    drained("testpat");
    rd_seq(1'b0, 5, 1, 8'h06);
    rd_seq(1'b0, 0, 1, 8'h03);
    ack(1'b0);
`endif

    // Reset mid-line with bank 0 FULL: everything, including FULL state, is dropped.
    smp(12'd0, 1'b0, 1'b0, 1'b1); exp_fs++;
    exp_line_q.push_back('{bank: 1'b0, num: 9'd1, len: 10'd2});
    line(4, 12'd3100);
    drained("pre_reset");
    smp(12'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) smp(12'd3100, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midline_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    smp(12'd0, 1'b0, 1'b0, 1'b1); exp_fs++;
    exp_line_q.push_back('{bank: 1'b0, num: 9'd1, len: 10'd2});
    line(4, 12'd3200);
    rd_seq(1'b0, 0, 1, 8'd50);
    drained("post_reset");
    chk("final_frame_start", fs_cnt, exp_fs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
